sobel_core: RTL and testbench

Streaming 3x3 Sobel edge detector. It sits between the UART pixel receiver and the frame-buffer write controller in the image pipeline. It accepts a raster-ordered 8-bit greyscale frame one pixel per `pi_flag` pulse and buffers two previous lines internally. Per valid window position it produces one binarised edge pixel, `po_data` = 255 or 0, with a `po_flag` strobe. A COLS x ROWS input frame yields exactly (COLS-2) x (ROWS-2) output pixels: 198 x 198 = 39204 at the defaults, matching the frame-buffer depth.

---
 rtl/sobel_core.sv | 114 +++++++++++
 tb/tb_sobel_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_core.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 shift window and a
// four-stage pipeline that emits one binarised pixel per valid window position.
module sobel_core #(
    parameter int          COLS   = 200,
    parameter int          ROWS   = 200,
    parameter logic [10:0] THRESH = 11'd128
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       pi_flag,
    input  logic [7:0] pi_data,
    output logic       po_flag,
    output logic [7:0] po_data,
    output logic       po_done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    // Weighted column/row sum a + 2b + c, widened to 11-bit signed.
    function automatic logic signed [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c);
        return $signed({3'b000, a}) + ($signed({3'b000, b}) <<< 1) + $signed({3'b000, c});
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    lb1 [COLS];
    logic [7:0]    lb2 [COLS];
    logic [7:0]    win [1:3][1:3];

    logic               v1, d1, v2, d2, v3, d3;
    logic signed [10:0] gx, gy;
    logic [10:0]        mag;

    // NOTE: line buffers carry no reset so they map onto RAM; stale contents
    // only ever feed rows 0-1, which never produce output.
    always_ff @(posedge sclk) begin
        if (!rst && pi_flag) begin
            lb1[col] <= pi_data;
            lb2[col] <= lb1[col];
        end
    end

    // S1: counters and window shift. Buffer reads see pre-write data.
    always_ff @(posedge sclk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            v1  <= 1'b0;
            d1  <= 1'b0;
            for (int i = 1; i <= 3; i++)
                for (int j = 1; j <= 3; j++)
                    win[i][j] <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment, so every
            // read below sees the values from before this edge.
            v1 <= pi_flag && (row >= RW'(2)) && (col >= CW'(2));
            d1 <= pi_flag && (row == ROW_LAST) && (col == COL_LAST);
            if (pi_flag) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                for (int i = 1; i <= 3; i++) begin
                    win[i][1] <= win[i][2];
                    win[i][2] <= win[i][3];
                end
                win[1][3] <= lb2[col];
                win[2][3] <= lb1[col];
                win[3][3] <= pi_data;
            end
        end
    end

    // S2..S4: gradients, magnitude, threshold.
    always_ff @(posedge sclk) begin
        if (rst) begin
            v2      <= 1'b0;
            d2      <= 1'b0;
            v3      <= 1'b0;
            d3      <= 1'b0;
            gx      <= '0;
            gy      <= '0;
            mag     <= '0;
            po_flag <= 1'b0;
            po_done <= 1'b0;
            po_data <= '0;
        end else begin
            v2 <= v1;
            d2 <= d1;
            gx <= wsum(win[1][3], win[2][3], win[3][3]) - wsum(win[1][1], win[2][1], win[3][1]);
            gy <= wsum(win[3][1], win[3][2], win[3][3]) - wsum(win[1][1], win[1][2], win[1][3]);

            v3  <= v2;
            d3  <= d2;
            mag <= abs11(gx) + abs11(gy);

            po_flag <= v3;
            po_done <= d3;
            if (v3)
                po_data <= (mag >= THRESH) ? 8'd255 : 8'd0;
        end
    end

endmodule

// File: tb/tb_sobel_core.sv
// Directed bench for sobel_core on a reduced 10x8 frame; expected outputs are
// hand-derived from each test pattern's edge geometry.
module tb_sobel_core;

    localparam int COLS = 10;
    localparam int ROWS = 8;
    localparam int NOUT = (COLS - 2) * (ROWS - 2);

    logic       sclk = 1'b0;
    logic       rst;
    logic       pi_flag;
    logic [7:0] pi_data;
    logic       po_flag;
    logic [7:0] po_data;
    logic       po_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stray_done = 0;

    logic [7:0] exp_data [$];
    bit         exp_done [$];
    int         exp_cyc  [$];
    logic [7:0] cap_data [$];
    bit         cap_done [$];
    int         cap_cyc  [$];

    sobel_core #(.COLS(COLS), .ROWS(ROWS)) dut (
        .sclk    (sclk),
        .rst     (rst),
        .pi_flag (pi_flag),
        .pi_data (pi_data),
        .po_flag (po_flag),
        .po_data (po_data),
        .po_done (po_done)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    // Output monitor on the falling edge, away from the sampling edge.
    always @(negedge sclk) begin
        if (po_flag) begin
            cap_data.push_back(po_data);
            cap_done.push_back(po_done);
            cap_cyc.push_back(cyc);
        end else if (po_done) begin
            stray_done++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    // kind 0: flat val; kind 1: vertical edge at COLS/2; kind 2: step of val at ROWS/2.
    task automatic send_frame(input int kind, input logic [7:0] val, input int max_gap);
        logic [7:0] px;
        logic [7:0] ex;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (max_gap > 0) idle($urandom_range(0, max_gap));
                case (kind)
                    1:       px = (c >= COLS / 2) ? 8'd255 : 8'd0;
                    2:       px = (r >= ROWS / 2) ? val : 8'd0;
                    default: px = val;
                endcase
                // Gradient is nonzero only for windows straddling the step;
                // a full step of s gives mag 4*s, so 255 -> 1020, 32 -> 128, 31 -> 124.
                case (kind)
                    1:       ex = (c == COLS / 2 || c == COLS / 2 + 1) ? 8'd255 : 8'd0;
                    2:       ex = ((r == ROWS / 2 || r == ROWS / 2 + 1) && val >= 8'd32) ? 8'd255 : 8'd0;
                    default: ex = 8'd0;
                endcase
                pi_flag = 1'b1;
                pi_data = px;
                if (r >= 2 && c >= 2) begin
                    exp_data.push_back(ex);
                    exp_done.push_back(r == ROWS - 1 && c == COLS - 1);
                    exp_cyc.push_back(cyc + 4);
                end
                @(posedge sclk);
                #1;
                pi_flag = 1'b0;
            end
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        idle(8);
        checks++;
        assert (cap_data.size() === exp_data.size()) else begin
            errors++;
            $error("FAIL %s count: got %0d expected %0d", tag, cap_data.size(), exp_data.size());
        end
        n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (cap_data[i] === exp_data[i]) else begin
                errors++;
                $error("FAIL %s data[%0d]: got %0d expected %0d", tag, i, cap_data[i], exp_data[i]);
            end
            checks++;
            assert (cap_done[i] === exp_done[i]) else begin
                errors++;
                $error("FAIL %s done[%0d]: got %0d expected %0d", tag, i, cap_done[i], exp_done[i]);
            end
            checks++;
            assert (cap_cyc[i] === exp_cyc[i]) else begin
                errors++;
                $error("FAIL %s latency[%0d]: got cycle %0d expected %0d", tag, i, cap_cyc[i], exp_cyc[i]);
            end
        end
        exp_data.delete();
        exp_done.delete();
        exp_cyc.delete();
        cap_data.delete();
        cap_done.delete();
        cap_cyc.delete();
    endtask

    initial begin
        rst     = 1'b1;
        pi_flag = 1'b1;
        pi_data = 8'd200;
        idle(3);

        checks++;
        assert (po_flag === 1'b0) else begin
            errors++; $error("FAIL reset po_flag: got %0b expected 0", po_flag);
        end
        checks++;
        assert (po_done === 1'b0) else begin
            errors++; $error("FAIL reset po_done: got %0b expected 0", po_done);
        end
        checks++;
        assert (po_data === 8'd0) else begin
            errors++; $error("FAIL reset po_data: got %0d expected 0", po_data);
        end
        pi_flag = 1'b0;
        rst     = 1'b0;
        idle(2);
        checks++;
        assert (cap_data.size() === 0) else begin
            errors++; $error("FAIL reset pi_flag ignored: got %0d strobes expected 0", cap_data.size());
        end

        // Mid-frame reset: edge pixels in flight must be discarded.
        for (int i = 0; i < 3 * COLS + 5; i++) begin
            pi_flag = 1'b1;
            pi_data = ((i % COLS) >= COLS / 2) ? 8'd255 : 8'd0;
            @(posedge sclk);
            #1;
        end
        pi_flag = 1'b0;
        rst     = 1'b1;
        idle(1);
        cap_data.delete();
        cap_done.delete();
        cap_cyc.delete();
        idle(1);
        rst = 1'b0;
        idle(4);
        checks++;
        assert (cap_data.size() === 0) else begin
            errors++; $error("FAIL midreset flush: got %0d strobes expected 0", cap_data.size());
        end
        checks++;
        assert (po_data === 8'd0) else begin
            errors++; $error("FAIL midreset po_data: got %0d expected 0", po_data);
        end

        send_frame(0, 8'd100, 0);
        check_stream("after_reset_flat");

        send_frame(0, 8'd100, 0);
        check_stream("flat");

        send_frame(1, 8'd0, 0);
        check_stream("vedge");

        send_frame(2, 8'd32, 0);
        check_stream("thresh32");

        send_frame(2, 8'd31, 0);
        check_stream("thresh31");

        send_frame(1, 8'd0, 5);
        check_stream("vedge_gapped");

        send_frame(1, 8'd0, 0);
        send_frame(0, 8'd100, 0);
        checks++;
        assert (exp_data.size() === 2 * NOUT) else begin
            errors++; $error("FAIL consec expected length: got %0d expected %0d", exp_data.size(), 2 * NOUT);
        end
        check_stream("consec");

        checks++;
        assert (stray_done === 0) else begin
            errors++; $error("FAIL stray po_done: got %0d expected 0", stray_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
